// File: rtl/debounce_pulse_if.sv
// Button conditioner signal bundle: raw button in, debounced level and strobes out.
interface debounce_pulse_if;
  logic button_i;
  logic pressed_o;
  logic press_pulse_o;
  logic release_pulse_o;

  modport master (
    output button_i,
    input  pressed_o,
    input  press_pulse_o,
    input  release_pulse_o
  );

  modport slave (
    input  button_i,
    output pressed_o,
    output press_pulse_o,
    output release_pulse_o
  );
endinterface

// File: rtl/debounce_pulse.sv
// Synchronise, debounce and strobe one raw button input.
// Optional auto-repeat of press strobes while held: `define DEBOUNCE_AUTO_REPEAT_EN.
module debounce_pulse #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned BOUNCE_TICKS  = 100000,
  parameter int unsigned REPEAT_DELAY  = 5000000,
  parameter int unsigned REPEAT_PERIOD = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  debounce_pulse_if.slave bus
);

  localparam int unsigned CW = $clog2(BOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BOUNCE_TICKS);

  localparam logic [1:0] S_RELEASED   = 2'd0;
  localparam logic [1:0] S_WAIT_PRESS = 2'd1;
  localparam logic [1:0] S_PRESSED    = 2'd2;
  localparam logic [1:0] S_WAIT_REL   = 2'd3;

  if (SYNC_STAGES < 2 || BOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("debounce_pulse: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pressed_q, pressed_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   rep_fire;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RELEASED: begin
        if (sync_s) begin
          state_d = S_WAIT_PRESS;
          cnt_d   = CW'(1);
        end
      end
      S_WAIT_PRESS: begin
        if (!sync_s)                state_d = S_RELEASED;
        else if (cnt_q == CNT_MAX)  state_d = S_PRESSED;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      S_PRESSED: begin
        if (!sync_s) begin
          state_d = S_WAIT_REL;
          cnt_d   = CW'(1);
        end
      end
      default: begin
        if (sync_s)                 state_d = S_PRESSED;
        else if (cnt_q == CNT_MAX)  state_d = S_RELEASED;
        else                        cnt_d   = cnt_q + CW'(1);
      end
    endcase
  end

  // Outputs are computed from the next state so they change on the same edge as the FSM.
  always_comb begin
    pressed_d = (state_d == S_PRESSED) || (state_d == S_WAIT_REL);
    press_d   = (pressed_d && !pressed_q) || rep_fire;
    release_d = !pressed_d && pressed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= S_RELEASED;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.button_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rpt_q, rpt_d;
  logic          phase_q, phase_d;

  // Timer only advances while settled in S_PRESSED; S_WAIT_REL holds it, release clears it.
  always_comb begin
    rpt_d    = rpt_q;
    phase_d  = phase_q;
    rep_fire = 1'b0;
    if (state_q == S_RELEASED || state_q == S_WAIT_PRESS) begin
      rpt_d   = '0;
      phase_d = 1'b0;
    end else if (state_q == S_PRESSED && sync_s) begin
      if (rpt_q == (phase_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1))) begin
        rep_fire = 1'b1;
        rpt_d    = '0;
        phase_d  = 1'b1;
      end else begin
        rpt_d = rpt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      rpt_q   <= rpt_d;
      phase_q <= phase_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign bus.pressed_o       = pressed_q;
  assign bus.press_pulse_o   = press_q;
  assign bus.release_pulse_o = release_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse with SYNC_STAGES=2, BOUNCE_TICKS=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_debounce_pulse;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] cnt_q;
  int n_cmp = 0;
  int n_bad = 0;

  debounce_pulse_if bus_if ();

  debounce_pulse #(
    .SYNC_STAGES  (2),
    .BOUNCE_TICKS (4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  always #5 clk = ~clk;

  // Downstream counter enabled by press_pulse.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (bus_if.press_pulse_o) cnt_q <= cnt_q + 8'd1;
  end

  typedef struct {
    logic       rst;
    logic       btn;
    logic [2:0] exp;  // {pressed, press_pulse, release_pulse}
  } vec_t;

  vec_t vecs[30];

  function automatic logic exp_pp_table(input int k);
    logic r;
    r = (k == 6);
`ifdef DEBOUNCE_AUTO_REPEAT_EN
    r = r || (k == 16) || (k == 19);
`endif
    return r;
  endfunction

  function automatic logic exp_pp_hold(input int k);
    logic r;
    r = (k == 6);
`ifdef DEBOUNCE_AUTO_REPEAT_EN
    r = r || (k >= 16 && ((k - 16) % 3) == 0);
`endif
    return r;
  endfunction

  task automatic step(input logic r, input logic b);
    @(negedge clk);
    rst = r;
    bus_if.button_i = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check3(input string name, input int k, input logic [2:0] exp);
    logic [2:0] act;
    act = {bus_if.pressed_o, bus_if.press_pulse_o, bus_if.release_pulse_o};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s edge %0d: {pressed,press,release} got %b want %b", name, k, act, exp);
    end
  endtask

  task automatic reset_dut();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    bus_if.button_i = 1'b0;

    for (int k = 0; k < 30; k++) begin
      vecs[k].rst = 1'b0;
      vecs[k].btn = (k < 20);
      vecs[k].exp = {(k >= 6 && k <= 25), exp_pp_table(k), (k == 26)};
    end

    reset_dut();
    check3("reset_state", -1, 3'b000);

    // Clean press at edge 0, release at edge 20.
    for (int k = 0; k < 30; k++) begin
      step(vecs[k].rst, vecs[k].btn);
      check3("press_release", k, vecs[k].exp);
    end

    // Bounce 1,0,1,0 then steady 1 from edge 4.
    reset_dut();
    for (int k = 0; k < 13; k++) begin
      step(1'b0, (k >= 4) ? 1'b1 : ((k % 2) == 0));
      check3("bounce", k, {(k >= 10), (k == 10), 1'b0});
    end

    // Two-cycle glitch must be rejected.
    reset_dut();
    for (int k = 0; k < 12; k++) begin
      step(1'b0, (k < 2));
      check3("glitch", k, 3'b000);
    end

    // Reset during debounce, button held throughout.
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1);
      check3("pre_rst", k, 3'b000);
    end
    for (int k = 4; k < 7; k++) begin
      step(1'b1, 1'b1);
      check3("in_rst", k, 3'b000);
    end
    for (int k = 7; k < 16; k++) begin
      step(1'b0, 1'b1);
      check3("post_rst", k, {(k >= 13), (k == 13), 1'b0});
    end

    // Long hold: press strobes (and repeats when enabled) counted downstream.
    reset_dut();
    for (int k = 0; k < 38; k++) begin
      step(1'b0, 1'b1);
      if (k >= 6) check3("hold", k, {1'b1, exp_pp_hold(k), 1'b0});
    end
    n_cmp++;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
    if (cnt_q !== 8'd8) begin
      n_bad++;
      $display("FAIL press_count: got %0d want %0d", cnt_q, 8);
    end
`else
    if (cnt_q !== 8'd1) begin
      n_bad++;
      $display("FAIL press_count: got %0d want %0d", cnt_q, 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
